// File: rtl/gpio_mmio_ctrl.sv
// Memory-mapped GPIO peripheral: synchronised and debounced inputs with sticky
// rising-edge status and a maskable interrupt, plus a writable output register.
module gpio_mmio_ctrl #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   GPIO_i,
    output logic [OUT_W-1:0]  GPIO_o,
    input  logic [3:0]        addr,
    input  logic              we,
    input  logic              re,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              irq
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    localparam logic [3:0] ADDR_DATA_IN  = 4'h0;
    localparam logic [3:0] ADDR_DATA_OUT = 4'h4;
    localparam logic [3:0] ADDR_STATUS   = 4'h8;
    localparam logic [3:0] ADDR_EN       = 4'hC;

    logic [IN_W-1:0]  sync1;
    logic [IN_W-1:0]  sync2;
    logic [IN_W-1:0]  deb;
    logic [IN_W-1:0]  deb_next;
    logic [CW-1:0]    cnt      [IN_W];
    logic [CW-1:0]    cnt_next [IN_W];
    logic [IN_W-1:0]  rise;
    logic [IN_W-1:0]  edge_status;
    logic [IN_W-1:0]  edge_en;
    logic [IN_W-1:0]  clr_mask;
    logic [OUT_W-1:0] data_out;
    logic [31:0]      rd_mux;
    logic             wr_out;
    logic             wr_status;
    logic             wr_en;
    logic             unused_wdata;

    assign unused_wdata = ^wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= GPIO_i;
            sync2 <= sync1;
        end
    end

    // A bit is accepted only after DEB_CYCLES consecutive disagreeing samples;
    // any sample matching the accepted value throws away the partial count.
    always_comb begin
        deb_next = deb;
        for (int i = 0; i < IN_W; i++) begin
            cnt_next[i] = cnt[i];
            if (sync2[i] == deb[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                deb_next[i] = sync2[i];
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb <= '0;
            for (int i = 0; i < IN_W; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb <= deb_next;
            for (int i = 0; i < IN_W; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign rise      = deb_next & ~deb;
    assign wr_out    = we && (addr == ADDR_DATA_OUT);
    assign wr_status = we && (addr == ADDR_STATUS);
    assign wr_en     = we && (addr == ADDR_EN);
    assign clr_mask  = wr_status ? wdata[IN_W-1:0] : '0;

    // New rising edges are ORed in after the W1C clear so a coincident set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out    <= '0;
            edge_status <= '0;
            edge_en     <= '0;
            irq         <= 1'b0;
        end else begin
            if (wr_out) begin
                data_out <= wdata[OUT_W-1:0];
            end
            if (wr_en) begin
                edge_en <= wdata[IN_W-1:0];
            end
            edge_status <= (edge_status & ~clr_mask) | rise;
            irq         <= |(edge_status & edge_en);
        end
    end

    assign GPIO_o = data_out;

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_DATA_IN:  rd_mux[IN_W-1:0]  = deb;
            ADDR_DATA_OUT: rd_mux[OUT_W-1:0] = data_out;
            ADDR_STATUS:   rd_mux[IN_W-1:0]  = edge_status;
            ADDR_EN:       rd_mux[IN_W-1:0]  = edge_en;
            default:       rd_mux            = '0;
        endcase
    end

    // Read data is sampled from pre-edge register values, so a same-cycle
    // write to the same address is not visible until the following read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_gpio_mmio_ctrl.sv
// Scoreboard testbench for gpio_mmio_ctrl: expected read data is queued when a
// read is issued and checked when rvalid returns; pin-level outputs checked directly.
module tb_gpio_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  GPIO_i;
    logic [7:0]  GPIO_o;
    logic [3:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    int vectors = 0;
    int misses  = 0;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];

    gpio_mmio_ctrl #(.IN_W(8), .OUT_W(8), .DEB_CYCLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .GPIO_i (GPIO_i),
        .GPIO_o (GPIO_o),
        .addr   (addr),
        .we     (we),
        .re     (re),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            misses++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("rvalid_unexpected", {31'b0, rvalid}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput(e.tag, rdata, e.value);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic readReg(input string tag, input logic [3:0] a, input logic [31:0] expv);
        exp_t e;
        e.tag   = tag;
        e.value = expv;
        sb.push_back(e);
        addr = a;
        re   = 1'b1;
        @(negedge clk);
        re   = 1'b0;
    endtask

    // Back-to-back reads starting on the cycle an input change is applied:
    // the first six return the old value, the seventh sees the accepted one.
    task automatic readSweep(input string tag, input logic [31:0] late);
        for (int i = 1; i <= 8; i++) begin
            readReg($sformatf("%s_%0d", tag, i), 4'h0, (i <= 6) ? 32'h0 : late);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b0;
        GPIO_i = 8'hFF;
        addr   = 4'h0;
        we     = 1'b0;
        re     = 1'b0;
        wdata  = '0;
        tick(3);
        checkOutput("rst_gpio_o", {24'b0, GPIO_o}, 32'h0);
        checkOutput("rst_irq", {31'b0, irq}, 32'h0);
        checkOutput("rst_rvalid", {31'b0, rvalid}, 32'h0);

        rst = 1'b1;
        readSweep("rst_datain", 32'hFF);
        readReg("rst_status", 4'h8, 32'hFF);
        GPIO_i = 8'h00;
        tick(10);
        applyStimulus(4'h8, 32'hFF);
        readReg("status_cleared", 4'h8, 32'h0);
        readReg("datain_low", 4'h0, 32'h0);

        GPIO_i = 8'h01;
        tick(3);
        GPIO_i = 8'h00;
        tick(8);
        readReg("glitch_datain", 4'h0, 32'h0);
        readReg("glitch_status", 4'h8, 32'h0);

        GPIO_i = 8'h01;
        readSweep("deb_datain", 32'h01);
        readReg("deb_status", 4'h8, 32'h01);
        applyStimulus(4'h8, 32'h01);
        checkOutput("deb_irq_disabled", {31'b0, irq}, 32'h0);

        applyStimulus(4'hC, 32'h01);
        GPIO_i = 8'h00;
        tick(10);
        readReg("fall_not_flagged", 4'h8, 32'h0);
        GPIO_i = 8'h01;
        tick(6);
        checkOutput("irq_before", {31'b0, irq}, 32'h0);
        tick(1);
        checkOutput("irq_set", {31'b0, irq}, 32'h1);
        readReg("irq_status", 4'h8, 32'h01);
        applyStimulus(4'h8, 32'h01);
        checkOutput("irq_hold", {31'b0, irq}, 32'h1);
        tick(1);
        checkOutput("irq_cleared", {31'b0, irq}, 32'h0);
        readReg("w1c_status", 4'h8, 32'h0);

        GPIO_i = 8'h09;
        tick(5);
        applyStimulus(4'h8, 32'h08);
        readReg("set_wins", 4'h8, 32'h08);
        checkOutput("set_wins_irq", {31'b0, irq}, 32'h0);
        applyStimulus(4'h8, 32'h08);
        readReg("set_then_clear", 4'h8, 32'h0);

        applyStimulus(4'h4, 32'hDEADBEA5);
        checkOutput("gpio_o_a5", {24'b0, GPIO_o}, 32'hA5);
        readReg("dataout_rd", 4'h4, 32'hA5);
        readReg("unmapped_2", 4'h2, 32'h0);
        readReg("unmapped_d", 4'hD, 32'h0);
        readReg("unmapped_e", 4'hE, 32'h0);
        applyStimulus(4'h6, 32'hFF);
        checkOutput("misaligned_wr", {24'b0, GPIO_o}, 32'hA5);
        readReg("en_rd", 4'hC, 32'h01);
        applyStimulus(4'hC, 32'hFFFFFFFF);
        readReg("en_upper", 4'hC, 32'hFF);
        applyStimulus(4'hC, 32'h01);

        applyStimulus(4'h4, 32'h11);
        begin
            exp_t e;
            e.tag   = "rdw_old";
            e.value = 32'h11;
            sb.push_back(e);
            addr  = 4'h4;
            wdata = 32'h22;
            we    = 1'b1;
            re    = 1'b1;
            @(negedge clk);
            we    = 1'b0;
            re    = 1'b0;
        end
        readReg("rdw_new", 4'h4, 32'h22);
        checkOutput("rdw_gpio_o", {24'b0, GPIO_o}, 32'h22);
        tick(1);
        checkOutput("rvalid_idle", {31'b0, rvalid}, 32'h0);

        GPIO_i = 8'h29;
        tick(3);
        rst = 1'b0;
        #1;
        checkOutput("midrst_gpio_o", {24'b0, GPIO_o}, 32'h0);
        checkOutput("midrst_irq", {31'b0, irq}, 32'h0);
        tick(2);
        rst = 1'b1;
        readSweep("midrst_datain", 32'h29);
        readReg("midrst_status", 4'h8, 32'h29);
        readReg("midrst_dataout", 4'h4, 32'h0);

        tick(2);
        checkOutput("sb_empty", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
